// File: rtl/riscv_stream_bridge.sv
// riscv_stream_bridge
//   Stream adapter for one RISC-V stream channel. Instantiate one of these per
//   channel.
//
//   Ingress half: a FIFO buffers upstream valid/ready words. It presents the
//   head word, held stable, on cpu_din/cpu_val_in. It pops one word for each
//   cpu_ready_upward pulse.
//
//   Egress half: a FIFO captures each single-cycle cpu_val_out/cpu_dout pulse.
//   It replays the captured words downstream as a valid/ready stream.
//
//   Both FIFOs are first-word-fall-through circular buffers with registered
//   occupancy counts.
//
// Ports
//   clk, resetn              clock (posedge), synchronous active-low reset
//   s_data/s_valid/s_ready   upstream stream into the ingress FIFO
//   cpu_din/cpu_val_in       ingress head word toward picorv_mem
//   cpu_ready_upward         one-cycle pop pulse from picorv_mem
//   cpu_dout/cpu_val_out     one-cycle push pulse from picorv_mem
//   cpu_ready_downward       egress FIFO has space
//   m_data/m_valid/m_ready   downstream stream out of the egress FIFO
//   in_count/out_count       FIFO occupancies
//   err_underflow            sticky: pop pulse arrived while ingress was empty
//   err_overflow             sticky: push pulse arrived while egress was full
module riscv_stream_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_AW      = 4,
  parameter int OUT_AW     = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] cpu_din,
  output logic                  cpu_val_in,
  input  logic                  cpu_ready_upward,
  input  logic [DATA_WIDTH-1:0] cpu_dout,
  input  logic                  cpu_val_out,
  output logic                  cpu_ready_downward,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [IN_AW:0]        in_count,
  output logic [OUT_AW:0]       out_count,
  output logic                  err_underflow,
  output logic                  err_overflow
);

  localparam int unsigned IN_DEPTH  = 1 << IN_AW;
  localparam int unsigned OUT_DEPTH = 1 << OUT_AW;

  // ---------------- ingress FIFO ----------------
  logic [DATA_WIDTH-1:0] in_mem_q [IN_DEPTH];
  logic [IN_AW-1:0]      in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [IN_AW:0]        in_cnt_q, in_cnt_d;
  logic                  in_full, in_empty, in_push, in_pop;

  // The count never exceeds the depth, so its MSB is set exactly when the
  // FIFO is full.
  assign in_full  = in_cnt_q[IN_AW];
  assign in_empty = (in_cnt_q == '0);

  assign s_ready    = resetn && !in_full;
  assign cpu_val_in = resetn && !in_empty;
  assign cpu_din    = in_mem_q[in_rd_q];
  assign in_count   = in_cnt_q;

  assign in_push = s_valid && s_ready;
  assign in_pop  = cpu_ready_upward && !in_empty;

  always_comb begin
    in_wr_d  = in_wr_q;
    in_rd_d  = in_rd_q;
    in_cnt_d = in_cnt_q;
    if (in_push) in_wr_d = in_wr_q + IN_AW'(1);
    if (in_pop)  in_rd_d = in_rd_q + IN_AW'(1);
    case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + (IN_AW+1)'(1);
      2'b01:   in_cnt_d = in_cnt_q - (IN_AW+1)'(1);
      default: in_cnt_d = in_cnt_q;
    endcase
  end

  // The storage array has no reset.
  always_ff @(posedge clk) begin
    if (in_push) in_mem_q[in_wr_q] <= s_data;
  end

  // ---------------- egress FIFO ----------------
  logic [DATA_WIDTH-1:0] out_mem_q [OUT_DEPTH];
  logic [OUT_AW-1:0]     out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OUT_AW:0]       out_cnt_q, out_cnt_d;
  logic                  out_full, out_empty, out_push, out_pop;

  assign out_full  = out_cnt_q[OUT_AW];
  assign out_empty = (out_cnt_q == '0);

  assign cpu_ready_downward = resetn && !out_full;
  assign m_valid            = resetn && !out_empty;
  assign m_data             = out_mem_q[out_rd_q];
  assign out_count          = out_cnt_q;

  // Fullness is judged before any same-cycle pop, so a pulse that arrives
  // while the FIFO is full is dropped even if m_ready frees a slot.
  assign out_push = resetn && cpu_val_out && !out_full;
  assign out_pop  = m_valid && m_ready;

  always_comb begin
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    out_cnt_d = out_cnt_q;
    if (out_push) out_wr_d = out_wr_q + OUT_AW'(1);
    if (out_pop)  out_rd_d = out_rd_q + OUT_AW'(1);
    case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + (OUT_AW+1)'(1);
      2'b01:   out_cnt_d = out_cnt_q - (OUT_AW+1)'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (out_push) out_mem_q[out_wr_q] <= cpu_dout;
  end

  // ---------------- sticky error flags ----------------
  logic err_underflow_q, err_underflow_d;
  logic err_overflow_q,  err_overflow_d;

  always_comb begin
    err_underflow_d = err_underflow_q | (cpu_ready_upward && in_empty);
    err_overflow_d  = err_overflow_q  | (cpu_val_out && out_full);
  end

  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      in_wr_q         <= '0;
      in_rd_q         <= '0;
      in_cnt_q        <= '0;
      out_wr_q        <= '0;
      out_rd_q        <= '0;
      out_cnt_q       <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      in_wr_q         <= in_wr_d;
      in_rd_q         <= in_rd_d;
      in_cnt_q        <= in_cnt_d;
      out_wr_q        <= out_wr_d;
      out_rd_q        <= out_rd_d;
      out_cnt_q       <= out_cnt_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

endmodule

// File: tb/tb_riscv_stream_bridge.sv
// Testbench for riscv_stream_bridge.
//   The reference model is two bounded queues plus two sticky flags. On each
//   negedge the bench compares the DUT outputs against the model. It then
//   applies the handshakes that the next posedge will perform, using the
//   model's own occupancy.
module tb_riscv_stream_bridge;
  localparam int DW = 32;
  localparam int IAW = 4;
  localparam int OAW = 4;
  localparam int IDEPTH = 1 << IAW;
  localparam int ODEPTH = 1 << OAW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] cpu_din;
  logic          cpu_val_in;
  logic          cpu_ready_upward;
  logic [DW-1:0] cpu_dout;
  logic          cpu_val_out;
  logic          cpu_ready_downward;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [IAW:0]  in_count;
  logic [OAW:0]  out_count;
  logic          err_underflow;
  logic          err_overflow;

  riscv_stream_bridge #(.DATA_WIDTH(DW), .IN_AW(IAW), .OUT_AW(OAW)) dut (
    .clk(clk), .resetn(resetn),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cpu_din(cpu_din), .cpu_val_in(cpu_val_in), .cpu_ready_upward(cpu_ready_upward),
    .cpu_dout(cpu_dout), .cpu_val_out(cpu_val_out), .cpu_ready_downward(cpu_ready_downward),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .in_count(in_count), .out_count(out_count),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard queues. Accepted words are pushed here and popped on each
  // output handshake.
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] eg_q[$];
  bit exp_uf = 1'b0;
  bit exp_of = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor / reference model
  always @(negedge clk) begin
    bit in_push, in_pop, eg_push, eg_pop;
    chk("s_ready",            32'(s_ready),            32'(resetn && in_q.size() < IDEPTH));
    chk("cpu_val_in",         32'(cpu_val_in),         32'(resetn && in_q.size() > 0));
    chk("in_count",           32'(in_count),           32'(in_q.size()));
    chk("cpu_ready_downward", 32'(cpu_ready_downward), 32'(resetn && eg_q.size() < ODEPTH));
    chk("m_valid",            32'(m_valid),            32'(resetn && eg_q.size() > 0));
    chk("out_count",          32'(out_count),          32'(eg_q.size()));
    chk("err_underflow",      32'(err_underflow),      32'(exp_uf));
    chk("err_overflow",       32'(err_overflow),       32'(exp_of));
    if (resetn && in_q.size() > 0) chk("cpu_din", cpu_din, in_q[0]);
    if (resetn && eg_q.size() > 0) chk("m_data", m_data, eg_q[0]);

    if (!resetn) begin
      in_q.delete();
      eg_q.delete();
      exp_uf = 1'b0;
      exp_of = 1'b0;
    end else begin
      in_push = s_valid && (in_q.size() < IDEPTH);
      in_pop  = cpu_ready_upward && (in_q.size() > 0);
      if (cpu_ready_upward && in_q.size() == 0) exp_uf = 1'b1;
      eg_push = cpu_val_out && (eg_q.size() < ODEPTH);
      eg_pop  = m_ready && (eg_q.size() > 0);
      if (cpu_val_out && eg_q.size() == ODEPTH) exp_of = 1'b1;
      if (in_pop)  void'(in_q.pop_front());
      if (in_push) in_q.push_back(s_data);
      if (eg_pop)  void'(eg_q.pop_front());
      if (eg_push) eg_q.push_back(cpu_dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic up_pulse();
    cpu_ready_upward = 1'b1;
    tick();
    cpu_ready_upward = 1'b0;
  endtask

  task automatic out_pulse(input logic [DW-1:0] d);
    cpu_val_out = 1'b1;
    cpu_dout    = d;
    tick();
    cpu_val_out = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; s_valid = 1'b1; s_data = 32'hA5A50001;
    cpu_ready_upward = 1'b0; cpu_dout = '0; cpu_val_out = 1'b0; m_ready = 1'b0;
    repeat (3) tick();

    // First push lands on the first edge after release
    resetn = 1'b1;
    tick();
    s_data = 32'hA5A50002; tick();
    s_data = 32'hA5A50003; tick();
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (3) tick();
      up_pulse();
    end
    repeat (2) tick();

    // Fill ingress, overfill attempts, refill after one pop
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 32'h1000_0000 + 32'(i);
      tick();
    end
    s_data = 32'h2000_0000;
    up_pulse();
    tick();
    // Pop-with-push across pointer wrap
    cpu_ready_upward = 1'b1;
    for (int i = 0; i < 32; i++) begin
      s_data = 32'h3000_0000 + 32'(i);
      tick();
    end
    s_valid = 1'b0;
    repeat (IDEPTH) tick();
    cpu_ready_upward = 1'b0;
    tick();

    // Egress replay
    out_pulse(32'h11); tick();
    out_pulse(32'h22); tick();
    out_pulse(32'h33); tick();
    m_ready = 1'b1;
    repeat (5) tick();
    m_ready = 1'b0;

    // Egress fill, overflow, and full + pulse + pop in the same cycle
    for (int i = 0; i < ODEPTH; i++) out_pulse(32'h4000_0000 + 32'(i));
    out_pulse(32'hDEAD);
    tick();
    m_ready = 1'b1;
    out_pulse(32'hDEAD);
    repeat (ODEPTH + 3) tick();
    m_ready = 1'b0;

    // Underflow, then normal traffic, then simultaneous push/pop on empty
    up_pulse();
    repeat (2) tick();
    s_valid = 1'b1; s_data = 32'h5555_0001; tick();
    s_valid = 1'b0; tick();
    up_pulse();
    s_valid = 1'b1; s_data = 32'h5555_0002; cpu_ready_upward = 1'b1; tick();
    s_valid = 1'b0; cpu_ready_upward = 1'b0; tick();
    up_pulse();
    resetn = 1'b0; tick();
    resetn = 1'b1; repeat (2) tick();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      resetn           = ($urandom_range(0, 399) != 0);
      s_valid          = ($urandom_range(0, 99) < 60);
      s_data           = $urandom;
      cpu_ready_upward = ($urandom_range(0, 99) < 45);
      cpu_val_out      = ($urandom_range(0, 99) < 55);
      cpu_dout         = $urandom;
      m_ready          = ($urandom_range(0, 99) < 40);
      tick();
    end
    s_valid = 1'b0; cpu_ready_upward = 1'b0; cpu_val_out = 1'b0; m_ready = 1'b0;
    resetn = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_stream_bridge.md
Name: riscv_stream_bridge

Overview:
- Stream adapter on one RISC-V stream channel, between the fabric's valid/ready streams and picorv_mem's per-channel stream pins.
- Ingress half: a FIFO buffers upstream words and presents the head word, held stable, to picorv_mem's din/val_in. It pops one word per ready_upward pulse.
- Egress half: a FIFO captures each single-cycle val_out/dout pulse from picorv_mem and replays it downstream with valid/ready.
- One instance per channel, four instances total.

Parameters:
- DATA_WIDTH, 32, stream word width.
- IN_AW, 4, ingress FIFO address bits; depth 2**IN_AW.
- OUT_AW, 4, egress FIFO address bits; depth 2**OUT_AW.

Ports:
- clk  input  1  clock; all logic on posedge.
- resetn  input  1  synchronous active-low reset.
- s_data  input  DATA_WIDTH  upstream word.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  ingress not full.
- cpu_din  output  DATA_WIDTH  ingress head word; connects to picorv_mem din.
- cpu_val_in  output  1  ingress not empty; connects to picorv_mem val_in.
- cpu_ready_upward  input  1  one-cycle pop pulse from picorv_mem.
- cpu_dout  input  DATA_WIDTH  word from picorv_mem dout.
- cpu_val_out  input  1  one-cycle push pulse from picorv_mem val_out.
- cpu_ready_downward  output  1  egress has space; connects to picorv_mem ready_downward.
- m_data  output  DATA_WIDTH  egress head word.
- m_valid  output  1  egress not empty.
- m_ready  input  1  downstream accept.
- in_count  output  IN_AW+1  ingress occupancy.
- out_count  output  OUT_AW+1  egress occupancy.
- err_underflow  output  1  sticky: pop pulse arrived while ingress empty.
- err_overflow  output  1  sticky: val_out pulse arrived while egress full.

Behaviour:
- Reset (resetn low at posedge):
  - all pointers and counts go to 0; error flags clear.
  - s_ready=0, cpu_val_in=0, m_valid=0, cpu_ready_downward=0 while resetn is low.
  - cpu_din and m_data are don't-care while the matching valid is low.
  - Memory contents are not cleared.
  - Reset mid-operation discards all buffered words.
- Each FIFO:
  - circular buffer with wr_ptr/rd_ptr of AW bits (wrap modulo depth) and a registered count of AW+1 bits.
  - full = (count == 2**AW); empty = (count == 0).
  - Head data is read combinationally from storage at rd_ptr, i.e. first-word-fall-through.
- Ingress:
  - s_ready = resetn && !in_full.
  - Push on s_valid && s_ready.
  - Pop on cpu_ready_upward && !in_empty.
  - cpu_val_in = !in_empty.
  - cpu_din = mem[rd_ptr]; it must stay constant while cpu_val_in=1 and no pop occurs.
- Egress:
  - Push on cpu_val_out && !out_full, writing cpu_dout.
  - cpu_ready_downward = resetn && !out_full (level).
  - m_valid = !out_empty; m_data = mem[rd_ptr].
  - Pop on m_valid && m_ready.
- Latency:
  - word accepted at edge N is visible at the head (valid=1) after edge N; no combinational path from s_valid/s_data to cpu_val_in/cpu_din.
  - Same for the cpu_val_out to m_valid path.
- Count update per edge: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Boundary conditions:
  - Simultaneous push and pop when full: ingress cannot push (s_ready=0).
  - Egress full with a val_out pulse and m_ready pop in the same cycle: word dropped, because full is evaluated before the pop.
  - Simultaneous push and pop when empty: pop is not performed (empty), push is performed, count becomes 1.
  - cpu_ready_upward while ingress empty: ignored, err_underflow <= 1.
  - cpu_val_out while egress full: word dropped, err_overflow <= 1, pointers unchanged.
  - Error flags clear only on reset.
  - Pointer wrap: after 2**AW pushes, wr_ptr returns to 0; ordering is preserved across the wrap.
- No combinational path from m_ready to s_ready or from cpu_ready_upward to any output other than through registered state.

Test Plan:
- Reset with s_valid=1 held: s_ready=0, cpu_val_in=0 and in_count=0 throughout reset. First push occurs on the first edge after resetn=1.
- Push 0xA5A50001..0xA5A50003 back-to-back, then issue 3 cpu_ready_upward pulses spaced 4 cycles apart:
  - cpu_din shows 0xA5A50001, 0xA5A50002, 0xA5A50003 in order, each stable between pulses.
  - cpu_val_in falls after the third pop; in_count goes 3,2,1,0.
- Fill ingress with 16 words (IN_AW=4): s_ready=0 and in_count=16. One pop, then a push with s_valid held, gives in_count=16 again. Then 32 pops-with-push across wrap preserve sequence order.
- cpu_val_out pulses carrying 0x11, 0x22, 0x33 with m_ready=0, then m_ready=1: m_data delivers 0x11, 0x22, 0x33 on three consecutive cycles, then m_valid=0.
- Fill egress to 16 with m_ready=0, then a 17th pulse of 0xDEAD: cpu_ready_downward=0, err_overflow=1, out_count=16, and 0xDEAD never appears on m_data.
- cpu_ready_upward pulse with ingress empty: err_underflow=1 and stays 1; in_count=0; a subsequent push/pop pair behaves normally. Asserting resetn=0 for one cycle clears the flag.
